instr_fetch_buffer: RTL and testbench

- Parametrised slot-granular instruction buffer between the IFU and the Decode stage.
- Accepts up to two instructions per cycle (fetch pair with per-slot mask) and presents the two oldest instructions first-word-fall-through.
- Decode consumes 0, 1 or 2 instructions per cycle.
- Every slot carries its own PC and misaligned-exception flag, so exception addresses stay aligned with their instructions.

---
 rtl/instr_fetch_buffer.sv | 182 ++++++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// Slot-granular instruction buffer between the IFU and Decode.
// Optional same-cycle bypass when empty: define INSTQ_BYPASS_EN.
module instr_fetch_buffer #(
  parameter int DEPTH      = 8,
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq_valid_i,
  input  logic [1:0]              enq_mask_i,
  input  logic [2*INST_WIDTH-1:0] enq_inst_i,
  input  logic [ADDR_WIDTH-1:0]   enq_pc_i,
  input  logic                    enq_misaligned_i,
  output logic                    enq_ready_o,
  input  logic                    flush_i,
  input  logic [1:0]              deq_cnt_i,
  output logic                    deq0_valid_o,
  output logic [INST_WIDTH-1:0]   deq0_inst_o,
  output logic [ADDR_WIDTH-1:0]   deq0_pc_o,
  output logic                    deq0_exc_o,
  output logic                    deq1_valid_o,
  output logic [INST_WIDTH-1:0]   deq1_inst_o,
  output logic [ADDR_WIDTH-1:0]   deq1_pc_o,
  output logic                    deq1_exc_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  exc;
  } slot_t;

  slot_t          mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;

  slot_t          in0;
  slot_t          in1;
  logic [1:0]     n_in;
  logic           enq_ready;
  logic           enq_fire;
  logic           byp;
  logic [1:0]     req;
  logic [1:0]     n_deq;
  logic [1:0]     n_pop;
  logic [1:0]     n_wr;
  slot_t          w0;

  slot_t          s0;
  slot_t          s1;
  logic           v0;
  logic           v1;

  assign enq_ready = (count <= CW'(DEPTH - 2));
  assign enq_fire  = enq_valid_i & enq_ready & ~flush_i;
  assign req       = (deq_cnt_i == 2'd3) ? 2'd2 : deq_cnt_i;

`ifdef INSTQ_BYPASS_EN
  assign byp = enq_fire & (count == '0);
`else
  assign byp = 1'b0;
`endif

  // Compact the fetch pair into up to two ordered slots
  always_comb begin
    in0  = '0;
    in1  = '0;
    n_in = 2'd0;
    if (enq_misaligned_i) begin
      in0.pc  = enq_pc_i;
      in0.exc = 1'b1;
      n_in    = 2'd1;
    end else begin
      unique case (enq_mask_i)
        2'b01: begin
          in0.inst = enq_inst_i[INST_WIDTH-1:0];
          in0.pc   = enq_pc_i;
          n_in     = 2'd1;
        end
        2'b11: begin
          in0.inst = enq_inst_i[INST_WIDTH-1:0];
          in0.pc   = enq_pc_i;
          in1.inst = enq_inst_i[2*INST_WIDTH-1:INST_WIDTH];
          in1.pc   = enq_pc_i + ADDR_WIDTH'(4);
          n_in     = 2'd2;
        end
        2'b10: begin
          in0.inst = enq_inst_i[2*INST_WIDTH-1:INST_WIDTH];
          in0.pc   = enq_pc_i + ADDR_WIDTH'(4);
          n_in     = 2'd1;
        end
        default: begin
          n_in = 2'd0;
        end
      endcase
    end
  end

  // Clip dequeue to what is visible and size the write
  always_comb begin
    n_deq = 2'd0;
    n_pop = 2'd0;
    n_wr  = 2'd0;
    w0    = in0;
    if (!flush_i) begin
      if (byp) begin
        n_deq = (req > n_in) ? n_in : req;
        n_wr  = n_in - n_deq;
        w0    = (n_deq == 2'd0) ? in0 : in1;
      end else begin
        n_deq = (CW'(req) > count) ? count[1:0] : req;
        n_pop = n_deq;
        n_wr  = enq_fire ? n_in : 2'd0;
      end
    end
  end

  // Pointer and occupancy state; flush wins over enq/deq
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(n_pop);
      wr_ptr <= wr_ptr + PW'(n_wr);
      count  <= count + CW'(n_wr) - CW'(n_pop);
    end
  end

  // Slot storage; contents survive flush and reset
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (n_wr != 2'd0) begin
        mem[wr_ptr] <= w0;
      end
      if (n_wr == 2'd2) begin
        mem[wr_ptr + PW'(1)] <= in1;
      end
    end
  end

  // Head/head+1 view, zeroed when not valid
  always_comb begin
    v0 = (count != '0);
    v1 = (count >= CW'(2));
    s0 = mem[rd_ptr];
    s1 = mem[rd_ptr + PW'(1)];
`ifdef INSTQ_BYPASS_EN
    if (byp) begin
      v0 = (n_in != 2'd0);
      v1 = (n_in == 2'd2);
      s0 = in0;
      s1 = in1;
    end
`endif
    if (!v0) s0 = '0;
    if (!v1) s1 = '0;
  end

  assign enq_ready_o  = enq_ready;
  assign count_o      = count;
  assign deq0_valid_o = v0;
  assign deq0_inst_o  = s0.inst;
  assign deq0_pc_o    = s0.pc;
  assign deq0_exc_o   = s0.exc;
  assign deq1_valid_o = v1;
  assign deq1_inst_o  = s1.inst;
  assign deq1_pc_o    = s1.pc;
  assign deq1_exc_o   = s1.exc;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: queue model, directed
// scenarios with literal expectations, then random traffic.
module tb_instr_fetch_buffer;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        exc;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic [1:0]  enq_mask;
  logic [63:0] enq_inst;
  logic [63:0] enq_pc;
  logic        enq_mis;
  logic        enq_ready;
  logic        flush;
  logic [1:0]  deq_cnt;
  logic        d0_v, d1_v, d0_e, d1_e;
  logic [31:0] d0_i, d1_i;
  logic [63:0] d0_pc, d1_pc;
  logic [3:0]  count;

  int n_chk = 0;
  int n_fail = 0;

  slot_t q[$];
  slot_t inc[$];
  slot_t vis[$];

  always #5 clk = ~clk;

  instr_fetch_buffer #(
    .DEPTH(DEPTH), .INST_WIDTH(32), .ADDR_WIDTH(64)
  ) dut (
    .clk(clk), .rst(rst),
    .enq_valid_i(enq_valid), .enq_mask_i(enq_mask),
    .enq_inst_i(enq_inst), .enq_pc_i(enq_pc),
    .enq_misaligned_i(enq_mis), .enq_ready_o(enq_ready),
    .flush_i(flush), .deq_cnt_i(deq_cnt),
    .deq0_valid_o(d0_v), .deq0_inst_o(d0_i),
    .deq0_pc_o(d0_pc), .deq0_exc_o(d0_e),
    .deq1_valid_o(d1_v), .deq1_inst_o(d1_i),
    .deq1_pc_o(d1_pc), .deq1_exc_o(d1_e),
    .count_o(count)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic build_inc();
    slot_t s;
    inc = {};
    if (enq_mis) begin
      s = '{inst: 32'd0, pc: enq_pc, exc: 1'b1};
      inc.push_back(s);
    end else begin
      if (enq_mask[0]) begin
        s = '{inst: enq_inst[31:0], pc: enq_pc, exc: 1'b0};
        inc.push_back(s);
      end
      if (enq_mask[1]) begin
        s = '{inst: enq_inst[63:32], pc: enq_pc + 64'd4, exc: 1'b0};
        inc.push_back(s);
      end
    end
  endtask

  task automatic step(input logic v, input logic [1:0] m,
                      input logic [63:0] ins, input logic [63:0] pc,
                      input logic mis, input logic fl,
                      input logic [1:0] dc);
    logic  fire, byp;
    int    req, n;
    slot_t e0, e1;
    enq_valid = v; enq_mask = m; enq_inst = ins;
    enq_pc = pc; enq_mis = mis; flush = fl; deq_cnt = dc;
    #1;
    build_inc();
    fire = v && (DEPTH - q.size() >= 2) && !fl;
    byp = 1'b0;
`ifdef INSTQ_BYPASS_EN
    byp = fire && (q.size() == 0);
`endif
    if (byp) vis = inc; else vis = q;
    e0 = (vis.size() >= 1) ? vis[0] : '0;
    e1 = (vis.size() >= 2) ? vis[1] : '0;
    chk("count", 64'(count), 64'(q.size()));
    chk("ready", 64'(enq_ready), 64'(DEPTH - q.size() >= 2));
    chk("d0_valid", 64'(d0_v), 64'(vis.size() >= 1));
    chk("d0_inst", 64'(d0_i), 64'(e0.inst));
    chk("d0_pc", d0_pc, e0.pc);
    chk("d0_exc", 64'(d0_e), 64'(e0.exc));
    chk("d1_valid", 64'(d1_v), 64'(vis.size() >= 2));
    chk("d1_inst", 64'(d1_i), 64'(e1.inst));
    chk("d1_pc", d1_pc, e1.pc);
    chk("d1_exc", 64'(d1_e), 64'(e1.exc));
    @(posedge clk);
    req = (dc == 2'd3) ? 2 : int'(dc);
    if (fl) begin
      q.delete();
    end else if (byp) begin
      n = (req < inc.size()) ? req : inc.size();
      for (int i = 0; i < n; i++) void'(inc.pop_front());
      foreach (inc[i]) q.push_back(inc[i]);
    end else begin
      n = (req < q.size()) ? req : q.size();
      for (int i = 0; i < n; i++) void'(q.pop_front());
      if (fire) foreach (inc[i]) q.push_back(inc[i]);
    end
    @(negedge clk);
    enq_valid = 1'b0; flush = 1'b0; deq_cnt = 2'd0;
    enq_mis = 1'b0; enq_mask = 2'b00;
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b0; enq_valid = 1'b0; enq_mask = 2'b00;
    enq_inst = '0; enq_pc = '0; enq_mis = 1'b0;
    flush = 1'b0; deq_cnt = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(enq_ready), 64'd1);
    chk("rst_d0v", 64'(d0_v), 64'd0);

    // pair fill
    for (int k = 0; k < 3; k++)
      step(1, 2'b11, rnd64(), 64'h1000, 0, 0, 0);
    chk("fill6_count", 64'(count), 64'd6);
    chk("fill6_ready", 64'(enq_ready), 64'd1);
    step(1, 2'b11, rnd64(), 64'h1000, 0, 0, 0);
    chk("fill8_count", 64'(count), 64'd8);
    chk("fill8_ready", 64'(enq_ready), 64'd0);
    chk("fill_d0pc", d0_pc, 64'h1000);
    chk("fill_d1pc", d1_pc, 64'h1004);
    step(1, 2'b11, rnd64(), 64'h9000, 0, 0, 0);
    chk("full_hold", 64'(count), 64'd8);

    // flush collision at count 4
    step(0, 2'b00, 0, 0, 0, 0, 2);
    step(0, 2'b00, 0, 0, 0, 0, 2);
    chk("pre_flush", 64'(count), 64'd4);
    step(1, 2'b11, rnd64(), 64'h5000, 0, 1, 2);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_d0v", 64'(d0_v), 64'd0);
    chk("flush_d1v", 64'(d1_v), 64'd0);
    step(1, 2'b11, rnd64(), 64'h5000, 0, 1, 0);
    chk("flush_empty", 64'(count), 64'd0);

    // partial and compacted
    step(1, 2'b10, rnd64(), 64'h2000, 0, 0, 0);
    step(1, 2'b01, rnd64(), 64'h3000, 0, 0, 0);
    chk("part_d0pc", d0_pc, 64'h2004);
    chk("part_d1pc", d1_pc, 64'h3000);
    chk("part_count", 64'(count), 64'd2);

    // misaligned exception
    step(0, 2'b00, 0, 0, 0, 1, 0);
    step(1, 2'b11, rnd64(), 64'h4002, 1, 0, 0);
    chk("exc_count", 64'(count), 64'd1);
    chk("exc_flag", 64'(d0_e), 64'd1);
    chk("exc_pc", d0_pc, 64'h4002);
    chk("exc_inst", 64'(d0_i), 64'd0);
    step(0, 2'b00, 0, 0, 0, 0, 3);
    chk("deq3_count", 64'(count), 64'd0);
    chk("deq3_d0v", 64'(d0_v), 64'd0);

    // steady state across pointer wrap
    step(1, 2'b11, rnd64(), 64'h8000, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step(1, 2'b11, rnd64(), 64'h8000 + 64'(8 * k), 0, 0, 2);
      chk("wrap_count", 64'(count), 64'd2);
      chk("wrap_d0pc", d0_pc, 64'h8000 + 64'(8 * k));
      chk("wrap_d1pc", d1_pc, 64'h8004 + 64'(8 * k));
    end

    // async reset with count 5
    step(0, 2'b00, 0, 0, 0, 1, 0);
    step(1, 2'b11, rnd64(), 64'h6000, 0, 0, 0);
    step(1, 2'b11, rnd64(), 64'h6008, 0, 0, 0);
    step(1, 2'b01, rnd64(), 64'h6010, 0, 0, 0);
    chk("pre_rst", 64'(count), 64'd5);
    #2 rst = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_d0v", 64'(d0_v), 64'd0);
    chk("arst_ready", 64'(enq_ready), 64'd1);
    chk("arst_d0pc", d0_pc, 64'd0);
    chk("arst_d1pc", d1_pc, 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;

    // random traffic, filling then draining bias
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), rnd64(),
           {$urandom, $urandom_range(0, 32'hffff) << 2},
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 24) == 0),
           2'(k < 300 ? $urandom_range(0, 1)
                      : $urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
